// File: rtl/stage_mem_pkg.sv
// rtl/stage_mem_pkg.sv - shared types and constants for the MEM pipeline stage
package stage_mem_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;
  localparam logic [4:0] ZERO_REG  = 5'd0;

  typedef struct packed {
    logic        valid;
    logic [31:0] ans;
    logic [4:0]  rw;
    logic [31:0] b;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
  } ex_mem_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/stage_mem_if.sv
// rtl/stage_mem_if.sv - data-memory request/ack bus
interface stage_mem_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/stage_mem_timer.sv
// rtl/stage_mem_timer.sv - access timeout counter
module stage_mem_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  // Count enabled cycles; clear restarts the count for the next access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires in the last allowed cycle, so the count reaches TIMEOUT at that edge.
  assign expired = enable && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/stage_mem.sv
// rtl/stage_mem.sv - MEM pipeline stage with EX/MEM register and dmem handshake
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_ex,
  input  logic [31:0] ans_ex,
  input  logic [4:0]  rw_ex,
  input  logic [31:0] b_ex,
  input  logic        reg_wr_ex,
  input  logic        mem_rd_ex,
  input  logic        mem_wr_ex,
  output logic        stall_mem,
  stage_mem_if.master dmem,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rw,
  output logic [31:0] wb_data,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rw,
  output logic [31:0] fwd_data,
  output logic        mem_err
);

  logic [0:0]  state;
  ex_mem_t     em;
  ex_mem_t     ex_in;
  logic        pend;
  logic        in_access;
  logic        acked;
  logic        expired;
  logic        timeout;
  logic        capture;
  logic        iss_go;
  logic [31:0] iss_ans;
  logic [4:0]  iss_rw;
  logic        iss_reg_wr;
  logic        iss_rd;
  logic        iss_wr;
  logic        iss_mem;
  logic        iss_bad;

  assign ex_in = '{valid: 1'b1, ans: ans_ex, rw: rw_ex, b: b_ex,
                   reg_wr: reg_wr_ex, mem_rd: mem_rd_ex, mem_wr: mem_wr_ex};

  assign in_access = (state == ST_ACCESS);
  assign acked     = in_access && dmem.dmem_ack;
  assign timeout   = expired && !dmem.dmem_ack;

  // The ack cycle releases EX; an op accepted then is parked in EX/MEM (pend)
  // and issued from there one cycle later, while the load result drains to WB.
  assign stall_mem = (in_access && !dmem.dmem_ack) || pend;
  assign capture   = valid_ex && !stall_mem;

  // Issue source: the parked op if any, otherwise the live EX outputs.
  assign iss_go     = pend || (!in_access && valid_ex);
  assign iss_ans    = pend ? em.ans    : ans_ex;
  assign iss_rw     = pend ? em.rw     : rw_ex;
  assign iss_reg_wr = pend ? em.reg_wr : reg_wr_ex;
  assign iss_rd     = pend ? em.mem_rd : mem_rd_ex;
  assign iss_wr     = pend ? em.mem_wr : mem_wr_ex;
  assign iss_mem    = iss_rd || iss_wr;
  assign iss_bad    = iss_mem && is_misaligned(iss_ans[1:0]);

  stage_mem_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!in_access),
    .enable  (in_access),
    .expired (expired)
  );

  // IDLE <-> ACCESS: enter on an aligned memory op, leave on ack or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (in_access) begin
      if (acked || timeout) state <= ST_IDLE;
    end else if (iss_go && iss_mem && !iss_bad) begin
      state <= ST_ACCESS;
    end
  end

  // EX/MEM register: load on capture, hold while stalled, bubble otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em   <= '0;
      pend <= 1'b0;
    end else if (capture) begin
      em   <= ex_in;
      pend <= acked;
    end else begin
      pend <= 1'b0;
      if (!stall_mem || timeout) em.valid <= 1'b0;
    end
  end

  // WB outputs and the error pulse, registered from completion events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rw    <= '0;
      wb_data  <= '0;
      mem_err  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      mem_err  <= 1'b0;
      if (acked) begin
        wb_valid <= 1'b1;
        wb_rw    <= em.rw;
        wb_data  <= em.mem_rd ? dmem.dmem_rdata : em.ans;
        wb_we    <= em.mem_rd && em.reg_wr && (em.rw != ZERO_REG);
      end else if (timeout) begin
        wb_valid <= 1'b1;
        wb_rw    <= em.rw;
        wb_data  <= em.ans;
        mem_err  <= 1'b1;
      end else if (iss_go && !(iss_mem && !iss_bad)) begin
        wb_valid <= 1'b1;
        wb_rw    <= iss_rw;
        wb_data  <= iss_ans;
        wb_we    <= iss_reg_wr && !iss_mem && (iss_rw != ZERO_REG);
        mem_err  <= iss_bad;
      end
    end
  end

  assign dmem.dmem_req   = in_access;
  assign dmem.dmem_we    = em.mem_wr;
  assign dmem.dmem_addr  = em.ans;
  assign dmem.dmem_wdata = em.b;

  assign fwd_valid = em.valid && em.reg_wr && !em.mem_rd && (em.rw != ZERO_REG);
  assign fwd_rw    = em.rw;
  assign fwd_data  = em.ans;

endmodule

// File: tb/tb_stage_mem.sv
// tb/tb_stage_mem.sv - scoreboard testbench for stage_mem
module tb_stage_mem;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_ex, reg_wr_ex, mem_rd_ex, mem_wr_ex;
  logic [31:0] ans_ex, b_ex;
  logic [4:0]  rw_ex;
  logic        stall_mem, wb_valid, wb_we, fwd_valid, mem_err;
  logic [4:0]  wb_rw, fwd_rw;
  logic [31:0] wb_data, fwd_data;

  always #5 clk = ~clk;

  stage_mem_if dmem_bus ();

  stage_mem #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_ex  (valid_ex),
    .ans_ex    (ans_ex),
    .rw_ex     (rw_ex),
    .b_ex      (b_ex),
    .reg_wr_ex (reg_wr_ex),
    .mem_rd_ex (mem_rd_ex),
    .mem_wr_ex (mem_wr_ex),
    .stall_mem (stall_mem),
    .dmem      (dmem_bus),
    .wb_valid  (wb_valid),
    .wb_we     (wb_we),
    .wb_rw     (wb_rw),
    .wb_data   (wb_data),
    .fwd_valid (fwd_valid),
    .fwd_rw    (fwd_rw),
    .fwd_data  (fwd_data),
    .mem_err   (mem_err)
  );

  typedef struct {
    logic        we;
    logic [4:0]  rw;
    logic [31:0] data;
    logic        err;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
  } mem_plan_t;

  wb_exp_t   exp_q[$];
  mem_plan_t plan_q[$];
  int        checks = 0;
  int        errors = 0;
  int        stall_cnt = 0, req_cnt = 0, err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: the WB result an op must produce, from the stage rules.
  task automatic issue(input logic [31:0] ans, input logic [4:0] rw, input logic [31:0] b,
                       input logic reg_wr, input logic rd, input logic wr,
                       input int lat, input logic [31:0] rdata);
    wb_exp_t   e;
    mem_plan_t p;
    int        n;
    e.rw = rw; e.data = ans; e.err = 1'b0; e.we = 1'b0;
    if (!rd && !wr) e.we = reg_wr && (rw != 0);
    else if (ans % 4 != 0) e.err = 1'b1;
    else if (lat >= TIMEOUT) e.err = 1'b1;
    else if (rd) begin e.we = reg_wr && (rw != 0); e.data = rdata; end
    p.we = wr; p.addr = ans; p.wdata = b; p.lat = lat; p.rdata = rdata;
    @(negedge clk);
    valid_ex = 1'b1; ans_ex = ans; rw_ex = rw; b_ex = b;
    reg_wr_ex = reg_wr; mem_rd_ex = rd; mem_wr_ex = wr;
    #1;
    n = 0;
    while (stall_mem && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL issue_accept actual=stalled required=accepted");
    end else begin
      exp_q.push_back(e);
      if ((rd || wr) && ans % 4 == 0) plan_q.push_back(p);
    end
    @(posedge clk); #1;
    valid_ex = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || dmem_bus.dmem_req) && n < 200) begin
      @(posedge clk); n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    repeat (3) @(posedge clk);
  endtask

  // Memory responder: follows the plan of each request, late-acks a timeout.
  logic      r_active = 1'b0;
  int        r_cyc = 0;
  mem_plan_t r_cur;
  initial begin
    dmem_bus.dmem_ack = 1'b0;
    dmem_bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_bus.dmem_ack = 1'b0;
      if (!rst_n) begin
        r_active = 1'b0;
      end else if (dmem_bus.dmem_req) begin
        if (!r_active) begin
          r_active = 1'b1; r_cyc = 0;
          if (plan_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_unexpected actual=req required=no_req");
            r_cur = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, lat: 1000, rdata: 32'h0};
          end else begin
            r_cur = plan_q.pop_front();
          end
        end
        r_cyc++;
        check("dmem_we", 32'(dmem_bus.dmem_we), 32'(r_cur.we));
        check("dmem_addr", dmem_bus.dmem_addr, r_cur.addr);
        if (r_cur.we) check("dmem_wdata", dmem_bus.dmem_wdata, r_cur.wdata);
        if (r_cyc == r_cur.lat + 1) begin
          dmem_bus.dmem_ack = 1'b1;
          dmem_bus.dmem_rdata = r_cur.rdata;
          r_active = 1'b0;
        end
      end else if (r_active) begin
        check("timeout_len", 32'(r_cyc), 32'(TIMEOUT));
        r_active = 1'b0;
        dmem_bus.dmem_ack = 1'b1;
        dmem_bus.dmem_rdata = 32'hBAD0BAD0;
      end
    end
  end

  // Scoreboard monitor: every WB presentation pops and checks one expectation.
  initial begin
    wb_exp_t e;
    forever begin
      @(posedge clk); #1;
      if (rst_n && wb_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected actual=wb_valid required=idle rw=%0d", wb_rw);
        end else begin
          e = exp_q.pop_front();
          check("wb_we", 32'(wb_we), 32'(e.we));
          check("wb_rw", 32'(wb_rw), 32'(e.rw));
          if (e.we) check("wb_data", wb_data, e.data);
          check("mem_err", 32'(mem_err), 32'(e.err));
        end
      end else if (rst_n && mem_err) begin
        check("mem_err_no_wb", 32'(mem_err), 32'd0);
      end
    end
  end

  // Cycle sampler: activity counters and forwarding invariants.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (stall_mem) stall_cnt++;
      if (dmem_bus.dmem_req) req_cnt++;
      if (mem_err) err_cnt++;
      if (dmem_bus.dmem_req && !dmem_bus.dmem_we) check("fwd_during_load", 32'(fwd_valid), 32'd0);
      if (fwd_valid) check("fwd_rw_nonzero", 32'(fwd_rw != 5'd0), 32'd1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int r;
    valid_ex = 1'b0; ans_ex = '0; rw_ex = '0; b_ex = '0;
    reg_wr_ex = 1'b0; mem_rd_ex = 1'b0; mem_wr_ex = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(stall_mem), 32'd0);
    check("rst_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    check("rst_addr", dmem_bus.dmem_addr, 32'd0);
    rst_n = 1'b1;

    stall_cnt = 0;
    issue(32'h1234, 5'd5, 32'h0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    check("alu_fwd_valid", 32'(fwd_valid), 32'd1);
    check("alu_fwd_rw", 32'(fwd_rw), 32'd5);
    check("alu_fwd_data", fwd_data, 32'h1234);
    wait_idle();
    check("alu_stall_cycles", 32'(stall_cnt), 32'd0);

    stall_cnt = 0; req_cnt = 0;
    issue(32'h100, 5'd8, 32'h0, 1'b1, 1'b1, 1'b0, 3, 32'hDEADBEEF);
    wait_idle();
    check("lw_stall_cycles", 32'(stall_cnt), 32'd3);
    check("lw_req_cycles", 32'(req_cnt), 32'd4);

    stall_cnt = 0; req_cnt = 0;
    issue(32'h200, 5'd9, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 0, 32'h0);
    wait_idle();
    check("sw_req_cycles", 32'(req_cnt), 32'd1);
    check("sw_stall_cycles", 32'(stall_cnt), 32'd0);

    req_cnt = 0; err_cnt = 0;
    issue(32'h102, 5'd4, 32'h0, 1'b1, 1'b1, 1'b0, 0, 32'h0);
    wait_idle();
    check("misalign_req_cycles", 32'(req_cnt), 32'd0);
    check("misalign_err_pulses", 32'(err_cnt), 32'd1);

    req_cnt = 0; err_cnt = 0; stall_cnt = 0;
    issue(32'h300, 5'd6, 32'h0, 1'b1, 1'b1, 1'b0, 40, 32'h0);
    wait_idle();
    check("to_req_cycles", 32'(req_cnt), 32'(TIMEOUT));
    check("to_err_pulses", 32'(err_cnt), 32'd1);
    check("to_stall_cycles", 32'(stall_cnt), 32'(TIMEOUT));
    issue(32'h55, 5'd3, 32'h0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    wait_idle();
    check("to_after_req_cycles", 32'(req_cnt), 32'(TIMEOUT));

    issue(32'h400, 5'd7, 32'h0, 1'b1, 1'b1, 1'b0, 40, 32'h0);
    repeat (4) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("arst_stall", 32'(stall_mem), 32'd0);
    check("arst_wb_valid", 32'(wb_valid), 32'd0);
    exp_q.delete();
    plan_q.delete();
    @(negedge clk); #3 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("arst_idle_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("arst_idle_stall", 32'(stall_mem), 32'd0);
    issue(32'hCAFE0000, 5'd10, 32'h0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    wait_idle();

    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 99));
      a = $urandom();
      if (r < 8) begin
        @(negedge clk);
      end else if (r < 50) begin
        issue(a, 5'($urandom_range(0, 31)), $urandom(), ($urandom_range(0, 3) != 0),
              1'b0, 1'b0, 0, 32'h0);
      end else if (r < 70) begin
        a[1:0] = 2'b00;
        issue(a, 5'($urandom_range(0, 31)), $urandom(), ($urandom_range(0, 3) != 0),
              1'b1, 1'b0, int'($urandom_range(0, 5)), $urandom());
      end else if (r < 88) begin
        a[1:0] = 2'b00;
        issue(a, 5'($urandom_range(0, 31)), $urandom(), 1'b0,
              1'b0, 1'b1, int'($urandom_range(0, 5)), 32'h0);
      end else if (r < 95) begin
        a[1:0] = 2'($urandom_range(1, 3));
        issue(a, 5'($urandom_range(0, 31)), $urandom(), 1'b1,
              r[0], !r[0], 0, 32'h0);
      end else begin
        a[1:0] = 2'b00;
        issue(a, 5'($urandom_range(1, 31)), $urandom(), 1'b1,
              1'b1, 1'b0, int'($urandom_range(20, 30)), $urandom());
      end
    end
    wait_idle();
    check("final_exp_empty", 32'(exp_q.size()), 32'd0);
    check("final_plan_empty", 32'(plan_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
